// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns upstream transfer commands into SETUP/ACCESS phases on two slaves.
// Optional ACCESS wait-state timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              transfer,
  input  logic              READ_WRITE,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_read_data_out,
  output logic              PSLVRR,
  output logic              xfer_done,
  output logic              busy,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-2:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    $error("apb_master_bridge: TIMEOUT_CYCLES must be nonzero");
  end

  // Incoming command as it would be latched this cycle
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              timeout_hit;
  logic              access_done;
  logic              start_cmd;

  assign cmd_addr  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
  assign cmd_wdata = READ_WRITE ? '0 : apb_write_data;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts ACCESS cycles spent waiting for PREADY; restarts on every ACCESS entry
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign access_done = (state == ACCESS) && (PREADY || timeout_hit);
  assign start_cmd   = transfer && ((state == IDLE) || access_done);

  // FSM with registered APB and upstream outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state             <= IDLE;
      apb_read_data_out <= '0;
      PSLVRR            <= 1'b0;
      xfer_done         <= 1'b0;
      busy              <= 1'b0;
      PSEL1             <= 1'b0;
      PSEL2             <= 1'b0;
      PENABLE           <= 1'b0;
      PWRITE            <= 1'b0;
      PADDR             <= '0;
      PWDATA            <= '0;
    end else begin
      xfer_done <= 1'b0;

      case (state)
        IDLE: begin
          PSEL1   <= 1'b0;
          PSEL2   <= 1'b0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
        end

        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end

        ACCESS: begin
          if (access_done) begin
            xfer_done <= 1'b1;
            PSLVRR    <= timeout_hit ? 1'b1 : PSLVERR;
            if (PREADY && !PWRITE && !PSLVERR) begin
              apb_read_data_out <= PRDATA;
            end
            state   <= IDLE;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          PSEL1   <= 1'b0;
          PSEL2   <= 1'b0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

      // New command from IDLE or back-to-back at completion; overrides the IDLE return
      if (start_cmd) begin
        state   <= SETUP;
        busy    <= 1'b1;
        PENABLE <= 1'b0;
        PSEL1   <= ~cmd_addr[ADDR_W-1];
        PSEL2   <= cmd_addr[ADDR_W-1];
        PADDR   <= cmd_addr[ADDR_W-2:0];
        PWRITE  <= ~READ_WRITE;
        PWDATA  <= cmd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: completions are checked against a queue of expected transfers.
// Timeout case is exercised only when built with APB_TIMEOUT_EN.
module tb_apb_master_bridge;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;

  logic              PCLK;
  logic              PRESET;
  logic              transfer;
  logic              READ_WRITE;
  logic [ADDR_W-1:0] apb_write_paddr;
  logic [DATA_W-1:0] apb_write_data;
  logic [ADDR_W-1:0] apb_read_paddr;
  logic [DATA_W-1:0] apb_read_data_out;
  logic              PSLVRR;
  logic              xfer_done;
  logic              busy;
  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-2:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .PSLVRR(PSLVRR), .xfer_done(xfer_done), .busy(busy),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave model: PREADY after wait_states ACCESS cycles, or never when stuck
  int   wait_states = 0;
  logic stuck       = 1'b0;
  logic [7:0] rdata_cfg = 8'h00;
  logic       err_cfg   = 1'b0;
  int   acc_cnt;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                  acc_cnt <= 0;
    else if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                         acc_cnt <= 0;
  end

  assign PREADY  = !stuck && PENABLE && (acc_cnt >= wait_states);
  assign PRDATA  = rdata_cfg;
  assign PSLVERR = err_cfg;

  typedef struct {
    logic       sel1;
    logic       sel2;
    logic [7:0] paddr;
    logic       pwrite;
    logic [7:0] pwdata;
    int         acc_len;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic expect_xfer(input logic s2, input logic [7:0] pa, input logic pw,
                             input logic [7:0] wd, input int len, input logic [7:0] rd,
                             input logic er);
    exp_t e;
    e.sel1 = ~s2; e.sel2 = s2; e.paddr = pa; e.pwrite = pw; e.pwdata = wd;
    e.acc_len = len; e.rdata = rd; e.err = er;
    exp_q.push_back(e);
  endtask

  // The unselected address port carries a decoy so the address mux is exercised
  task automatic issue(input logic rw, input logic [8:0] addr, input logic [7:0] data);
    transfer       = 1'b1;
    READ_WRITE     = rw;
    apb_write_data = data;
    if (rw) begin
      apb_read_paddr  = addr;
      apb_write_paddr = addr ^ 9'h1FF;
    end else begin
      apb_write_paddr = addr;
      apb_read_paddr  = addr ^ 9'h1FF;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge PCLK);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s: actual=busy after %0d cycles required=idle", name, n);
    end
  endtask

  // Monitor: records the ACCESS phase, checks it against the queue head on xfer_done
  int         run_len = 0;
  int         last_len = 0;
  logic       cap_sel1, cap_sel2, cap_pwrite;
  logic [7:0] cap_paddr, cap_pwdata;

  always @(negedge PCLK) begin
    exp_t e;
    if (PRESET) begin
      run_len = 0;
    end else begin
      if (PENABLE) begin
        run_len++;
        cap_sel1 = PSEL1; cap_sel2 = PSEL2; cap_pwrite = PWRITE;
        cap_paddr = PADDR; cap_pwdata = PWDATA;
      end else if (run_len != 0) begin
        last_len = run_len;
        run_len  = 0;
      end
      if (xfer_done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer_done: actual=pulse required=none");
        end else begin
          e = exp_q.pop_front();
          check("done_psel", {cap_sel1, cap_sel2}, {e.sel1, e.sel2});
          check("done_paddr", cap_paddr, e.paddr);
          check("done_pwrite", cap_pwrite, e.pwrite);
          check("done_pwdata", cap_pwdata, e.pwdata);
          check("done_access_len", last_len, e.acc_len);
          check("done_rdata_out", apb_read_data_out, e.rdata);
          check("done_pslvrr", PSLVRR, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; transfer = 1'b0; READ_WRITE = 1'b0;
    apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
    repeat (2) @(negedge PCLK);
    check("rst_ctrl", {PSEL1, PSEL2, PENABLE, busy, xfer_done, PSLVRR}, 6'b0);
    check("rst_rdata", apb_read_data_out, 8'h00);
    check("rst_bus", {PWRITE, PADDR, PWDATA}, 17'h0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // 1: write 0x5A to 0x005, zero wait states
    expect_xfer(1'b0, 8'h05, 1'b1, 8'h5A, 1, 8'h00, 1'b0);
    issue(1'b0, 9'h005, 8'h5A);
    @(negedge PCLK);
    transfer = 1'b0;
    check("t1_setup_ctrl", {PSEL1, PSEL2, PENABLE, busy}, 4'b1001);
    check("t1_setup_bus", {PWRITE, PADDR, PWDATA}, {1'b1, 8'h05, 8'h5A});
    @(negedge PCLK);
    check("t1_access_ctrl", {PSEL1, PSEL2, PENABLE}, 3'b101);
    @(negedge PCLK);
    check("t1_done_latency", xfer_done, 1'b1);
    check("t1_idle_ctrl", {PSEL1, PSEL2, PENABLE, busy}, 4'b0000);
    @(negedge PCLK);
    check("t1_done_pulse", xfer_done, 1'b0);

    // 2: read 0x1A3 with two wait states
    wait_states = 2; rdata_cfg = 8'hC3;
    expect_xfer(1'b1, 8'hA3, 1'b0, 8'h00, 3, 8'hC3, 1'b0);
    issue(1'b1, 9'h1A3, 8'hEE);
    @(negedge PCLK);
    transfer = 1'b0;
    check("t2_setup_sel", {PSEL1, PSEL2, PADDR, PWDATA}, {2'b01, 8'hA3, 8'h00});
    wait_idle("t2_wait");

    // 4: read error keeps previous data, next clean write clears the flag
    @(negedge PCLK);
    wait_states = 0; rdata_cfg = 8'h55; err_cfg = 1'b1;
    expect_xfer(1'b0, 8'hC4, 1'b0, 8'h00, 1, 8'hC3, 1'b1);
    issue(1'b1, 9'h0C4, 8'h00);
    @(negedge PCLK);
    transfer = 1'b0;
    wait_idle("t4_err_wait");
    check("t4_err_flag", PSLVRR, 1'b1);
    check("t4_err_rdata", apb_read_data_out, 8'hC3);
    @(negedge PCLK);
    err_cfg = 1'b0;
    expect_xfer(1'b1, 8'h20, 1'b1, 8'hA5, 1, 8'hC3, 1'b0);
    issue(1'b0, 9'h120, 8'hA5);
    @(negedge PCLK);
    transfer = 1'b0;
    wait_idle("t4_clr_wait");
    check("t4_err_cleared", PSLVRR, 1'b0);

    // 3: back-to-back write 0x010 then read 0x011 with transfer held
    @(negedge PCLK);
    rdata_cfg = 8'h96;
    expect_xfer(1'b0, 8'h10, 1'b1, 8'h77, 1, 8'hC3, 1'b0);
    expect_xfer(1'b0, 8'h11, 1'b0, 8'h00, 1, 8'h96, 1'b0);
    issue(1'b0, 9'h010, 8'h77);
    @(negedge PCLK);
    check("t3_setup1", {PSEL1, PENABLE}, 2'b10);
    issue(1'b1, 9'h011, 8'h77);
    @(negedge PCLK);
    check("t3_access1", {PSEL1, PENABLE, PADDR}, {2'b11, 8'h10});
    @(negedge PCLK);
    transfer = 1'b0;
    check("t3_setup2", {PSEL1, PENABLE, busy, PWRITE, PADDR}, {4'b1010, 8'h11});
    @(negedge PCLK);
    check("t3_access2", {PSEL1, PENABLE}, 2'b11);
    wait_idle("t3_wait");

    // 6: reset in the middle of ACCESS, then a clean restart
    @(negedge PCLK);
    wait_states = 5;
    issue(1'b1, 9'h0AA, 8'h00);
    @(negedge PCLK);
    transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    check("t6_in_access", {PSEL1, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    check("t6_rst_ctrl", {PSEL1, PSEL2, PENABLE, busy, xfer_done, PSLVRR}, 6'b0);
    check("t6_rst_rdata", apb_read_data_out, 8'h00);
    @(negedge PCLK);
    PRESET = 1'b0; wait_states = 0;
    @(negedge PCLK);
    expect_xfer(1'b0, 8'h03, 1'b1, 8'h11, 1, 8'h00, 1'b0);
    issue(1'b0, 9'h003, 8'h11);
    @(negedge PCLK);
    transfer = 1'b0;
    check("t6_restart_sel", {PSEL1, PENABLE, busy}, 3'b101);
    wait_idle("t6_wait");

`ifdef APB_TIMEOUT_EN
    // 5: slave never ready, transfer times out after 16 ACCESS cycles
    @(negedge PCLK);
    stuck = 1'b1;
    expect_xfer(1'b1, 8'h40, 1'b0, 8'h00, 16, 8'h00, 1'b1);
    issue(1'b1, 9'h140, 8'h00);
    @(negedge PCLK);
    transfer = 1'b0;
    wait_idle("t5_timeout_wait");
    check("t5_idle", {PSEL2, PENABLE, busy}, 3'b000);
    stuck = 1'b0;
`endif

    repeat (3) @(negedge PCLK);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
